// File: rtl/apb_slave_if.sv
// APB completer: turns each APB transfer into one valid/ready request on the local side,
// with a bounded wait. Optional byte strobes when APB_WSTRB_EN is defined.
module apb_slave_if #(
   parameter int APB_DATA_WIDTH = 32,
   parameter int APB_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLE  = 6
) (
   input  logic                        apb_clk_in,
   input  logic                        apb_rst_in,
   input  logic [APB_ADDR_WIDTH-1:0]   apb_addr_in,
   input  logic                        apb_psel_in,
   input  logic                        apb_penable_in,
   input  logic                        apb_write_in,
   input  logic [APB_DATA_WIDTH-1:0]   apb_wdata_in,
`ifdef APB_WSTRB_EN
   input  logic [APB_DATA_WIDTH/8-1:0] apb_strb_in,
   output logic [APB_DATA_WIDTH/8-1:0] other_strb_out,
`endif
   output logic [APB_DATA_WIDTH-1:0]   apb_rdata_out,
   output logic                        apb_ready_out,
   output logic                        apb_slverr_out,
   output logic                        other_valid_out,
   output logic                        other_write_out,
   output logic [APB_ADDR_WIDTH-1:0]   other_addr_out,
   output logic [APB_DATA_WIDTH-1:0]   other_wdata_out,
   input  logic [APB_DATA_WIDTH-1:0]   other_rdata_in,
   input  logic                        other_ready_in,
   input  logic                        other_error_in
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLE + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLE - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] wait_cnt;
   // Set when a request is rejected locally and must complete with an error without forwarding.
   logic             req_err;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge apb_clk_in) begin
      if (apb_rst_in) begin
         state           <= ST_IDLE;
         wait_cnt        <= '0;
         req_err         <= 1'b0;
         apb_rdata_out   <= '0;
         apb_ready_out   <= 1'b0;
         apb_slverr_out  <= 1'b0;
         other_valid_out <= 1'b0;
         other_write_out <= 1'b0;
         other_addr_out  <= '0;
         other_wdata_out <= '0;
`ifdef APB_WSTRB_EN
         other_strb_out  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (apb_psel_in && !apb_penable_in) begin
                  other_addr_out  <= apb_addr_in;
                  other_write_out <= apb_write_in;
                  other_wdata_out <= apb_wdata_in;
                  wait_cnt        <= '0;
                  state           <= ST_WAIT;
`ifdef APB_WSTRB_EN
                  other_strb_out  <= apb_write_in ? apb_strb_in : '0;
                  // A strobed read is malformed: answer it with an error instead of forwarding.
                  if (!apb_write_in && (apb_strb_in != '0)) begin
                     other_valid_out <= 1'b0;
                     req_err         <= 1'b1;
                  end else begin
                     other_valid_out <= 1'b1;
                     req_err         <= 1'b0;
                  end
`else
                  other_valid_out <= 1'b1;
                  req_err         <= 1'b0;
`endif
               end
            end
            ST_WAIT: begin
               if (!apb_psel_in) begin
                  other_valid_out <= 1'b0;
                  req_err         <= 1'b0;
                  state           <= ST_IDLE;
               end else if (req_err) begin
                  req_err        <= 1'b0;
                  apb_ready_out  <= 1'b1;
                  apb_slverr_out <= 1'b1;
                  apb_rdata_out  <= '0;
                  state          <= ST_RESP;
               end else if (other_ready_in) begin
                  apb_rdata_out   <= other_write_out ? '0 : other_rdata_in;
                  apb_slverr_out  <= other_error_in;
                  apb_ready_out   <= 1'b1;
                  other_valid_out <= 1'b0;
                  state           <= ST_RESP;
               end else if (wait_cnt == CNT_LAST) begin
                  apb_ready_out   <= 1'b1;
                  apb_slverr_out  <= 1'b1;
                  apb_rdata_out   <= '0;
                  other_valid_out <= 1'b0;
                  state           <= ST_RESP;
               end else begin
                  wait_cnt <= sat_inc(wait_cnt);
               end
            end
            ST_RESP: begin
               apb_ready_out  <= 1'b0;
               apb_slverr_out <= 1'b0;
               apb_rdata_out  <= '0;
               state          <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_slave_if.sv
// Scoreboard bench for apb_slave_if: stimulus pushes expected requests/responses,
// a negedge monitor pops and compares them.
module tb_apb_slave_if;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] paddr;
   logic          psel, penable, pwrite;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready, pslverr;
   logic          o_valid, o_write;
   logic [AW-1:0] o_addr;
   logic [DW-1:0] o_wdata;
   logic [DW-1:0] o_rdata;
   logic          o_ready, o_error;
   logic [3:0]    pstrb;
   logic [3:0]    o_strb;

   always #5 clk = ~clk;

   apb_slave_if #(.APB_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLE(TO)) dut (
      .apb_clk_in(clk),
      .apb_rst_in(rst),
      .apb_addr_in(paddr),
      .apb_psel_in(psel),
      .apb_penable_in(penable),
      .apb_write_in(pwrite),
      .apb_wdata_in(pwdata),
`ifdef APB_WSTRB_EN
      .apb_strb_in(pstrb),
      .other_strb_out(o_strb),
`endif
      .apb_rdata_out(prdata),
      .apb_ready_out(pready),
      .apb_slverr_out(pslverr),
      .other_valid_out(o_valid),
      .other_write_out(o_write),
      .other_addr_out(o_addr),
      .other_wdata_out(o_wdata),
      .other_rdata_in(o_rdata),
      .other_ready_in(o_ready),
      .other_error_in(o_error)
   );

`ifndef APB_WSTRB_EN
   assign o_strb = 4'b0000;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic          write;
      logic [DW-1:0] wdata;
      logic [3:0]    strb;
   } req_t;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            vcyc;
   } resp_t;

   req_t  req_q[$];
   resp_t resp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Local-side responder: raises ready on the (delay+1)-th cycle that valid is high.
   int            resp_delay = 0;
   logic          resp_never = 1'b0;
   logic [DW-1:0] resp_rdata = '0;
   logic          resp_err   = 1'b0;
   int            rv = 0;

   always @(negedge clk) begin
      if (o_valid) begin
         rv++;
         if (!resp_never && rv == resp_delay + 1) begin
            o_ready = 1'b1;
            o_rdata = resp_rdata;
            o_error = resp_err;
         end else begin
            o_ready = 1'b0;
            o_rdata = '0;
            o_error = 1'b0;
         end
      end else begin
         rv      = 0;
         o_ready = 1'b0;
         o_rdata = '0;
         o_error = 1'b0;
      end
   end

   // Monitor / scoreboard
   int   vcnt  = 0;
   int   vdone = 0;
   req_t cur;

   always @(negedge clk) begin
      if (rst) begin
         vcnt  = 0;
         vdone = 0;
      end else begin
         if (o_valid) begin
            vcnt++;
            if (vcnt == 1) begin
               if (req_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_req: got addr 0x%0h, expected no request", o_addr);
                  cur = '{addr: o_addr, write: o_write, wdata: o_wdata, strb: o_strb};
               end else begin
                  cur = req_q.pop_front();
                  chk("req_addr", 64'(o_addr), 64'(cur.addr));
                  chk("req_write", 64'(o_write), 64'(cur.write));
                  chk("req_wdata", 64'(o_wdata), 64'(cur.wdata));
`ifdef APB_WSTRB_EN
                  chk("req_strb", 64'(o_strb), 64'(cur.strb));
`endif
               end
            end else begin
               chk("req_hold_addr", 64'(o_addr), 64'(cur.addr));
               chk("req_hold_wdata", 64'(o_wdata), 64'(cur.wdata));
            end
         end else if (vcnt != 0) begin
            vdone = vcnt;
            vcnt  = 0;
         end
         if (pready) begin
            if (resp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pready: got pready=1, expected 0");
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               chk("resp_rdata", 64'(prdata), 64'(r.rdata));
               chk("resp_slverr", 64'(pslverr), 64'(r.err));
               chk("resp_valid_cycles", 64'(vdone), 64'(r.vcyc));
            end
            vdone = 0;
         end else begin
            chk("idle_rdata", 64'(prdata), 64'h0);
            chk("idle_slverr", 64'(pslverr), 64'h0);
         end
      end
   end

   task automatic setup_phase(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                              input logic [3:0] s);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
   endtask

   task automatic access_wait(input string name);
      int n;
      @(posedge clk); #1;
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pready && n < 40);
      if (!pready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_pready_timeout: got no pready in %0d cycles, expected pready", name, n);
      end
   endtask

   // Full transfer: configure responder, push expectations, run setup+access.
   task automatic xfer(input string name, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d, input logic [3:0] s,
                       input int dly, input logic never, input logic [DW-1:0] lrd, input logic lerr,
                       input logic fwd, input logic [3:0] exp_strb,
                       input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_vc);
      resp_delay = dly; resp_never = never; resp_rdata = lrd; resp_err = lerr;
      if (fwd) req_q.push_back('{addr: a, write: w, wdata: d, strb: exp_strb});
      resp_q.push_back('{rdata: exp_rd, err: exp_err, vcyc: exp_vc});
      setup_phase(a, w, d, s);
      access_wait(name);
   endtask

   task automatic bus_idle();
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
      paddr = 32'h4; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
      o_ready = 1'b0; o_rdata = '0; o_error = 1'b0;

      // Reset held two cycles with a bogus access phase on the bus
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pready", 64'(pready), 64'h0);
      chk("rst_slverr", 64'(pslverr), 64'h0);
      chk("rst_prdata", 64'(prdata), 64'h0);
      chk("rst_valid", 64'(o_valid), 64'h0);
      chk("rst_owrite", 64'(o_write), 64'h0);
      chk("rst_oaddr", 64'(o_addr), 64'h0);
      chk("rst_owdata", 64'(o_wdata), 64'h0);
      chk("rst_ostrb", 64'(o_strb), 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      // Access phase without a setup phase must be ignored
      repeat (3) begin
         @(negedge clk);
         chk("nosetup_valid", 64'(o_valid), 64'h0);
      end
      bus_idle();

      xfer("wr10", 32'h10, 1'b1, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'hFFFF_FFFF, 1'b0,
           1'b1, 4'hF, 32'h0, 1'b0, 1);
      bus_idle();
      xfer("rd24", 32'h24, 1'b0, 32'h0, 4'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0,
           1'b1, 4'h0, 32'hDEAD_BEEF, 1'b0, 4);
      bus_idle();
      xfer("rd_timeout", 32'h40, 1'b0, 32'h0, 4'h0, 0, 1'b1, 32'h0, 1'b0,
           1'b1, 4'h0, 32'h0, 1'b1, TO);
      bus_idle();
      xfer("wr_lerr", 32'h14, 1'b1, 32'h0000_1234, 4'hF, 1, 1'b0, 32'h0, 1'b1,
           1'b1, 4'hF, 32'h0, 1'b1, 2);
      // Back-to-back transfers, no idle cycle between them
      xfer("b2b_rd28", 32'h28, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0000_0042, 1'b0,
           1'b1, 4'h0, 32'h0000_0042, 1'b0, 1);
      xfer("b2b_wr2c", 32'h2C, 1'b1, 32'h5A5A_0002, 4'hF, 2, 1'b0, 32'h1111_1111, 1'b0,
           1'b1, 4'hF, 32'h0, 1'b0, 3);
      bus_idle();

      // Master abort after two WAIT cycles, then an immediate new setup to 0x30
      resp_never = 1'b1;
      req_q.push_back('{addr: 32'h20, write: 1'b0, wdata: 32'h0, strb: 4'h0});
      setup_phase(32'h20, 1'b0, 32'h0, 4'h0);
      @(posedge clk); #1;
      penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("abort_valid_still_high", 64'(o_valid), 64'h1);
      resp_never = 1'b0; resp_delay = 0; resp_rdata = 32'h0; resp_err = 1'b0;
      req_q.push_back('{addr: 32'h30, write: 1'b1, wdata: 32'hC0DE_0030, strb: 4'hF});
      resp_q.push_back('{rdata: 32'h0, err: 1'b0, vcyc: 1});
      setup_phase(32'h30, 1'b1, 32'hC0DE_0030, 4'hF);
      @(negedge clk);
      chk("abort_valid_dropped", 64'(o_valid), 64'h0);
      chk("abort_no_pready", 64'(pready), 64'h0);
      access_wait("after_abort_wr30");
      bus_idle();

`ifdef APB_WSTRB_EN
      xfer("strb_wr", 32'h50, 1'b1, 32'h0102_0304, 4'b0101, 0, 1'b0, 32'h0, 1'b0,
           1'b1, 4'b0101, 32'h0, 1'b0, 1);
      bus_idle();
      xfer("strb_wr_zero", 32'h54, 1'b1, 32'h0506_0708, 4'b0000, 0, 1'b0, 32'h0, 1'b0,
           1'b1, 4'b0000, 32'h0, 1'b0, 1);
      bus_idle();
      xfer("strb_rd_bad", 32'h58, 1'b0, 32'h0, 4'b0001, 0, 1'b0, 32'h9999_9999, 1'b0,
           1'b0, 4'b0000, 32'h0, 1'b1, 0);
      bus_idle();
`endif

      repeat (4) @(negedge clk);
      chk("req_queue_drained", 64'(req_q.size()), 64'h0);
      chk("resp_queue_drained", 64'(resp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/apb_slave_if.md
Name: apb_slave_if

Overview:
APB completer (slave) interface: the responder end of the APB link driven by the team's APB master interface.
- Decodes APB setup/access phases and forwards each transfer as a single valid/ready request to a local register or memory block ("other" side).
- Returns read data, PREADY and PSLVERR to the APB bus.
- Bounds local-side latency with a timeout counter that completes a stalled transfer with an error.

Parameters:
APB_DATA_WIDTH, 32, APB data bus width in bits (multiple of 8)
APB_ADDR_WIDTH, 32, APB address bus width in bits
TIMEOUT_CYCLE, 6, max cycles other_valid_out may stay high without other_ready_in before forced error completion (>=1)

Ports:
apb_clk_in  input  1  single clock; all logic on rising edge
apb_rst_in  input  1  reset, synchronous, active-high
apb_addr_in  input  APB_ADDR_WIDTH  PADDR
apb_psel_in  input  1  PSEL for this completer
apb_penable_in  input  1  PENABLE
apb_write_in  input  1  PWRITE (1 = write)
apb_wdata_in  input  APB_DATA_WIDTH  PWDATA
apb_rdata_out  output  APB_DATA_WIDTH  PRDATA
apb_ready_out  output  1  PREADY
apb_slverr_out  output  1  PSLVERR
other_valid_out  output  1  local request valid
other_write_out  output  1  local request direction
other_addr_out  output  APB_ADDR_WIDTH  local request address
other_wdata_out  output  APB_DATA_WIDTH  local write data
other_rdata_in  input  APB_DATA_WIDTH  local read data, valid with other_ready_in
other_ready_in  input  1  local request accepted/completed
other_error_in  input  1  local error, valid with other_ready_in

Behaviour:
Reset:
- Clock is apb_clk_in; reset is synchronous and active-high, applied on apb_clk_in rising edge while apb_rst_in=1.
- On reset all outputs are 0, state goes to IDLE and the timeout counter clears.
- Reset mid-transfer drops other_valid_out and apb_ready_out on the same edge; no response is issued.

States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE: on a sampled setup phase (psel=1, penable=0), latch addr/write/wdata into other_*_out, set other_valid_out=1, clear counter, go to WAIT. psel=1 with penable=1 in IDLE (no setup seen) is ignored.
- WAIT:
  - other_ready_in=1: capture other_rdata_in (reads only; writes capture 0), apb_slverr_out<=other_error_in, apb_ready_out<=1, other_valid_out<=0, go to RESP.
  - Otherwise, counter reaches TIMEOUT_CYCLE: apb_ready_out<=1, apb_slverr_out<=1, apb_rdata_out<=0, other_valid_out<=0, go to RESP.
  - Otherwise, counter increments.
  - psel=0 in WAIT (master abort) overrides both: other_valid_out<=0, go to IDLE, no response.
- RESP: apb_ready_out is high for exactly one cycle. Next edge clears apb_ready_out, apb_slverr_out and apb_rdata_out, and returns to IDLE.
  - IDLE evaluates setup in the following cycle, so back-to-back APB transfers are accepted with no idle gap required on the bus.

Timing and data:
- Minimum latency is setup cycle T0, then T1 with other_valid_out=1 (ready sampled), then T2 with PREADY=1. This gives one APB wait state minimum; each cycle of other_ready_in delay adds one.
- other_addr/write/wdata hold stable while other_valid_out=1. other_ready_in is only observed while other_valid_out=1.
- Timeout counter width is $clog2(TIMEOUT_CYCLE+1) and saturates; no wrap.
- apb_rdata_out is nonzero only in the PREADY cycle of a successful read.

Optional Feature:
APB_WSTRB_EN
- Defined: adds input apb_strb_in [APB_DATA_WIDTH/8] and output other_strb_out [APB_DATA_WIDTH/8].
  - Strobe is latched with address in IDLE; other_strb_out is forced to 0 for reads.
  - A read whose setup phase carries nonzero apb_strb_in is not forwarded: other_valid_out stays 0, and it completes via WAIT->RESP on the next edge with apb_slverr_out=1.
  - A write with apb_strb_in=0 is forwarded normally.
- Undefined: neither port exists; all writes are full-width.

Test Plan:
- Reset held 2 cycles with psel=1, penable=1 -> all outputs 0; after release no PREADY until a proper setup phase.
- Write addr 0x10, wdata 0xA5A5_0001, other_ready_in high immediately -> other_valid_out high 1 cycle with addr 0x10; PREADY high in cycle T2 with slverr=0.
- Read addr 0x24, other_ready_in after 3 cycles with rdata 0xDEAD_BEEF -> PREADY asserted once, 4 wait states, PRDATA=0xDEADBEEF in that cycle only, 0 after.
- Read with other_ready_in never asserted, TIMEOUT_CYCLE=6 -> PREADY with PSLVERR=1 and PRDATA=0 after 6 WAIT cycles; other_valid_out low from then on.
- psel dropped after 2 WAIT cycles -> other_valid_out low next edge, no PREADY; immediate new setup to 0x30 is served normally.
- APB_WSTRB_EN: write strb 4'b0101 -> other_strb_out=4'b0101; read with strb 4'b0001 -> other_valid_out never high, PSLVERR=1 on PREADY.
